serial_fifo_bridge: RTL and testbench
=====================================

Name: serial_fifo_bridge

Overview:
Byte-buffering bridge between the processor's serial IO ports (wired through data_memory) and an external host/UART front end. It has two independent FIFOs:
- RX FIFO: host to processor. The head is presented show-ahead as serial_in/serial_valid_in. It is popped by the processor's serial_rden_out.
- TX FIFO: processor to host. It captures serial_out on serial_wren_out and backpressures via serial_ready_in.
This decouples single-cycle load/store timing from host byte timing.

Parameters:
DEPTH, 16, entries per FIFO; power of two, at least 2.
AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
host_rx_data  in  8  byte from host.
host_rx_valid  in  1  host byte valid.
host_rx_ready  out  1  RX FIFO can accept a byte.
host_tx_data  out  8  TX FIFO head byte.
host_tx_valid  out  1  TX FIFO non-empty.
host_tx_ready  in  1  host accepts host_tx_data.
cpu_rx_data  out  8  RX head; wired to processor serial_in.
cpu_rx_valid  out  1  RX non-empty; wired to serial_valid_in.
cpu_rx_rden  in  1  processor consumed a byte; from serial_rden_out.
cpu_tx_data  in  8  processor byte; from serial_out.
cpu_tx_wren  in  1  processor write strobe; from serial_wren_out.
cpu_tx_ready  out  1  TX FIFO not full; wired to serial_ready_in.
rx_level  out  AW+1  RX occupancy, 0..DEPTH.
tx_level  out  AW+1  TX occupancy, 0..DEPTH.
err_rx_underflow  out  1  sticky: rden seen while RX empty.
err_tx_overflow  out  1  sticky: wren seen while TX full.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pointers, levels and sticky errors go to 0.
  - host_rx_ready=1, cpu_tx_ready=1, host_tx_valid=0, cpu_rx_valid=0.
  - FIFO contents are don't-care; data outputs read 0 while the FIFO is empty.
  - Reset mid-transfer discards all buffered bytes.
- Each FIFO:
  - Circular buffer with AW-bit read/write pointers that wrap modulo DEPTH, plus an (AW+1)-bit count.
  - full = (count==DEPTH); empty = (count==0).
- Push, RX FIFO: occurs when host_rx_valid & host_rx_ready.
- Push, TX FIFO: occurs when cpu_tx_wren & !full.
- Pop, RX FIFO: occurs when cpu_rx_rden & cpu_rx_valid.
- Pop, TX FIFO: occurs when host_tx_valid & host_tx_ready.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
  - When full, a simultaneous push is refused, because ready is computed from the current count; there is no pass-through.
- Show-ahead read:
  - Data output = mem[rd_ptr], combinational from registered pointer and storage.
  - valid = !empty.
  - A pushed byte is visible on the consumer side the cycle after the push edge (1-cycle latency).
- Ready outputs: host_rx_ready = !rx_full and cpu_tx_ready = !tx_full. Both are driven purely from registers, so there is no combinational path from valid to ready.
- Violations:
  - cpu_rx_rden with RX empty: ignored, and err_rx_underflow is set.
  - cpu_tx_wren with TX full: byte dropped, and err_tx_overflow is set.
  - Sticky flags clear only on reset.
- Host-side protocol is valid/ready: host_tx_data is held stable while host_tx_valid=1 and not accepted.
- Levels: rx_level and tx_level equal the respective registered count.

Optional Feature:
SERIAL_BRIDGE_STATS_EN:
- When defined, adds outputs rx_bytes_total and tx_bytes_total, each 16 bits.
  - They count successful CPU-side pops (RX) and pushes (TX).
  - They saturate at 16'hFFFF.
  - Reset to 0.
- When not defined, these ports and their counters are absent. Core behaviour is identical in both builds.

Decomposition:
- Package serial_bridge_pkg holds:
  - SER_DATA_W=8 and SER_DEFAULT_DEPTH=16.
  - A byte_t typedef (logic [7:0]).
  - STAT_W=16.
- Sub-module sync_fifo (parameters DEPTH and W):
  - Ports: push, pop, din, dout, full, empty, count.
  - Instantiated twice, once as rx_fifo and once as tx_fifo.
- The top level contains only handshake gating, sticky errors and the optional stats.

Test Plan:
- Reset release, then host pushes 8'hA5 and 8'h3C on consecutive cycles:
  - cpu_rx_valid rises 1 cycle after the first push, with cpu_rx_data=A5.
  - Pulse rden: data becomes 3C.
  - Second rden: valid drops and rx_level=0.
- CPU writes 16 bytes 0x00..0x0F with host_tx_ready=0:
  - cpu_tx_ready falls after the 16th byte and tx_level=16.
  - A 17th write of 0xFF is dropped and err_tx_overflow=1.
  - Draining yields 0x00..0x0F in order.
- RX full with simultaneous host_rx_valid and rden:
  - Pop occurs, push is refused, and level goes 16 to 15.
  - Next cycle the push is accepted and level returns to 16.
- Wrap-around: stream 40 bytes through TX with random host_tx_ready.
  - Output sequence matches input exactly and the pointers wrap twice.
- rden with RX empty: err_rx_underflow=1, level stays 0, and no pointer moves.
- Assert reset with 5 bytes queued in each FIFO:
  - Immediately (asynchronously): levels=0, valids=0, errors cleared, readies=1.
- With SERIAL_BRIDGE_STATS_EN:
  - 3 RX pops and 2 TX pushes give rx_bytes_total=3 and tx_bytes_total=2.
  - A counter forced to FFFF stays at FFFF on the next event.

Source files
------------

// File: rtl/serial_bridge_pkg.sv
// Shared types and constants for the serial FIFO bridge.
// The optional byte counters are built only when SERIAL_BRIDGE_STATS_EN is defined.
package serial_bridge_pkg;

  localparam int SER_DATA_W        = 8;
  localparam int SER_DEFAULT_DEPTH = 16;
  localparam int STAT_W            = 16;

  typedef logic [SER_DATA_W-1:0] byte_t;

  // Increment that holds at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/serial_fifo_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO: circular buffer with wrapping pointers and an occupancy count.
// The head is visible on dout the cycle after it is pushed; dout reads 0 while the FIFO is empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; contents only matter once
  // count says they are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_fifo_bridge.sv
// Byte bridge between the processor serial IO ports and a host front end: RX and TX FIFOs,
// handshake gating and sticky error flags. Define SERIAL_BRIDGE_STATS_EN for byte counters.
module serial_fifo_bridge
  import serial_bridge_pkg::*;
#(
  parameter int DEPTH = SER_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SER_DATA_W-1:0] host_rx_data,
  input  logic                  host_rx_valid,
  output logic                  host_rx_ready,
  output logic [SER_DATA_W-1:0] host_tx_data,
  output logic                  host_tx_valid,
  input  logic                  host_tx_ready,
  output logic [SER_DATA_W-1:0] cpu_rx_data,
  output logic                  cpu_rx_valid,
  input  logic                  cpu_rx_rden,
  input  logic [SER_DATA_W-1:0] cpu_tx_data,
  input  logic                  cpu_tx_wren,
  output logic                  cpu_tx_ready,
  output logic [AW:0]           rx_level,
  output logic [AW:0]           tx_level,
  output logic                  err_rx_underflow,
`ifdef SERIAL_BRIDGE_STATS_EN
  output logic [STAT_W-1:0]     rx_bytes_total,
  output logic [STAT_W-1:0]     tx_bytes_total,
`endif
  output logic                  err_tx_overflow
);

  logic rx_full, rx_empty, rx_push, rx_pop;
  logic tx_full, tx_empty, tx_push, tx_pop;

  // Ready depends only on registered counts, so a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign host_rx_ready = !rx_full;
  assign cpu_rx_valid  = !rx_empty;
  assign cpu_tx_ready  = !tx_full;
  assign host_tx_valid = !tx_empty;

  assign rx_push = host_rx_valid && host_rx_ready;
  assign rx_pop  = cpu_rx_rden && cpu_rx_valid;
  assign tx_push = cpu_tx_wren && cpu_tx_ready;
  assign tx_pop  = host_tx_valid && host_tx_ready;

  sync_fifo #(.DEPTH(DEPTH), .W(SER_DATA_W)) rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (host_rx_data),
    .dout  (cpu_rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_level)
  );

  sync_fifo #(.DEPTH(DEPTH), .W(SER_DATA_W)) tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (cpu_tx_data),
    .dout  (host_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_rx_underflow <= 1'b0;
      err_tx_overflow  <= 1'b0;
    end else begin
      if (cpu_rx_rden && rx_empty) err_rx_underflow <= 1'b1;
      if (cpu_tx_wren && tx_full)  err_tx_overflow  <= 1'b1;
    end
  end

`ifdef SERIAL_BRIDGE_STATS_EN
  logic [STAT_W-1:0] rx_total;
  logic [STAT_W-1:0] tx_total;

  assign rx_bytes_total = rx_total;
  assign tx_bytes_total = tx_total;

  // Only CPU-side traffic is counted: bytes the processor consumed or produced.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_total <= '0;
      tx_total <= '0;
    end else begin
      if (rx_pop)  rx_total <= sat_inc(rx_total);
      if (tx_push) tx_total <= sat_inc(tx_total);
    end
  end
`endif

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Directed self-checking bench for serial_fifo_bridge (DEPTH=16); stats checks build
// only when SERIAL_BRIDGE_STATS_EN is defined.
module tb_serial_fifo_bridge;
  import serial_bridge_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  host_rx_data = '0;
  logic        host_rx_valid = 1'b0;
  logic        host_rx_ready;
  logic [7:0]  host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready = 1'b0;
  logic [7:0]  cpu_rx_data;
  logic        cpu_rx_valid;
  logic        cpu_rx_rden = 1'b0;
  logic [7:0]  cpu_tx_data = '0;
  logic        cpu_tx_wren = 1'b0;
  logic        cpu_tx_ready;
  logic [4:0]  rx_level;
  logic [4:0]  tx_level;
  logic        err_rx_underflow;
  logic        err_tx_overflow;
`ifdef SERIAL_BRIDGE_STATS_EN
  logic [15:0] rx_bytes_total;
  logic [15:0] tx_bytes_total;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  serial_fifo_bridge #(.DEPTH(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .host_rx_data     (host_rx_data),
    .host_rx_valid    (host_rx_valid),
    .host_rx_ready    (host_rx_ready),
    .host_tx_data     (host_tx_data),
    .host_tx_valid    (host_tx_valid),
    .host_tx_ready    (host_tx_ready),
    .cpu_rx_data      (cpu_rx_data),
    .cpu_rx_valid     (cpu_rx_valid),
    .cpu_rx_rden      (cpu_rx_rden),
    .cpu_tx_data      (cpu_tx_data),
    .cpu_tx_wren      (cpu_tx_wren),
    .cpu_tx_ready     (cpu_tx_ready),
    .rx_level         (rx_level),
    .tx_level         (tx_level),
    .err_rx_underflow (err_rx_underflow),
`ifdef SERIAL_BRIDGE_STATS_EN
    .rx_bytes_total   (rx_bytes_total),
    .tx_bytes_total   (tx_bytes_total),
`endif
    .err_tx_overflow  (err_tx_overflow)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({host_rx_ready, cpu_tx_ready, host_tx_valid, cpu_rx_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_handshake: got %b want 1100",
               {host_rx_ready, cpu_tx_ready, host_tx_valid, cpu_rx_valid});
    end
    checks++;
    if ({rx_level, tx_level, err_rx_underflow, err_tx_overflow} !== 12'h000) begin
      errors++;
      $display("FAIL reset_levels_errs: rx_level=%0d tx_level=%0d uf=%b of=%b want 0",
               rx_level, tx_level, err_rx_underflow, err_tx_overflow);
    end
    checks++;
    if (cpu_rx_data !== 8'h00 || host_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: cpu_rx_data=%h host_tx_data=%h want 00", cpu_rx_data, host_tx_data);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_rx_basic();
    host_rx_valid = 1'b1;
    host_rx_data  = 8'hA5;
    tick();
    checks++;
    if (cpu_rx_valid !== 1'b1 || cpu_rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL rx_first_byte: valid=%b data=%h want 1 a5", cpu_rx_valid, cpu_rx_data);
    end
    host_rx_data = 8'h3C;
    tick();
    host_rx_valid = 1'b0;
    checks++;
    if (rx_level !== 5'd2 || cpu_rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL rx_two_queued: level=%0d data=%h want 2 a5", rx_level, cpu_rx_data);
    end
    cpu_rx_rden = 1'b1;
    tick();
    cpu_rx_rden = 1'b0;
    checks++;
    if (cpu_rx_data !== 8'h3C || rx_level !== 5'd1) begin
      errors++;
      $display("FAIL rx_after_pop1: data=%h level=%0d want 3c 1", cpu_rx_data, rx_level);
    end
    cpu_rx_rden = 1'b1;
    tick();
    cpu_rx_rden = 1'b0;
    checks++;
    if (cpu_rx_valid !== 1'b0 || rx_level !== 5'd0 || err_rx_underflow !== 1'b0) begin
      errors++;
      $display("FAIL rx_after_pop2: valid=%b level=%0d uf=%b want 0 0 0",
               cpu_rx_valid, rx_level, err_rx_underflow);
    end
  endtask

  task automatic test_tx_fill_overflow();
    host_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cpu_tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL tx_ready_before_full[%0d]: got %b want 1", i, cpu_tx_ready);
      end
      cpu_tx_wren = 1'b1;
      cpu_tx_data = 8'(i);
      tick();
    end
    cpu_tx_wren = 1'b0;
    checks++;
    if (cpu_tx_ready !== 1'b0 || tx_level !== 5'd16 || err_tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL tx_full: ready=%b level=%0d of=%b want 0 16 0",
               cpu_tx_ready, tx_level, err_tx_overflow);
    end
    cpu_tx_wren = 1'b1;
    cpu_tx_data = 8'hFF;
    tick();
    cpu_tx_wren = 1'b0;
    checks++;
    if (err_tx_overflow !== 1'b1 || tx_level !== 5'd16) begin
      errors++;
      $display("FAIL tx_overflow: of=%b level=%0d want 1 16", err_tx_overflow, tx_level);
    end
    host_tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (host_tx_valid !== 1'b1 || host_tx_data !== 8'(i)) begin
        errors++;
        $display("FAIL tx_drain[%0d]: valid=%b data=%h want 1 %h", i, host_tx_valid, host_tx_data, 8'(i));
      end
      tick();
    end
    host_tx_ready = 1'b0;
    checks++;
    if (host_tx_valid !== 1'b0 || tx_level !== 5'd0) begin
      errors++;
      $display("FAIL tx_drained: valid=%b level=%0d want 0 0", host_tx_valid, tx_level);
    end
  endtask

  task automatic test_rx_full_simultaneous();
    host_rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      host_rx_data = 8'(8'h10 + i);
      tick();
    end
    host_rx_data = 8'hEE;
    checks++;
    if (host_rx_ready !== 1'b0 || rx_level !== 5'd16) begin
      errors++;
      $display("FAIL rx_full: ready=%b level=%0d want 0 16", host_rx_ready, rx_level);
    end
    cpu_rx_rden = 1'b1;
    tick();
    cpu_rx_rden = 1'b0;
    checks++;
    if (rx_level !== 5'd15 || host_rx_ready !== 1'b1 || cpu_rx_data !== 8'h11) begin
      errors++;
      $display("FAIL rx_full_pop_no_push: level=%0d ready=%b data=%h want 15 1 11",
               rx_level, host_rx_ready, cpu_rx_data);
    end
    tick();
    host_rx_valid = 1'b0;
    checks++;
    if (rx_level !== 5'd16) begin
      errors++;
      $display("FAIL rx_refill: level=%0d want 16", rx_level);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i < 15) ? 8'(8'h11 + i) : 8'hEE;
      checks++;
      if (cpu_rx_data !== exp) begin
        errors++;
        $display("FAIL rx_full_drain[%0d]: data=%h want %h", i, cpu_rx_data, exp);
      end
      cpu_rx_rden = 1'b1;
      tick();
    end
    cpu_rx_rden = 1'b0;
  endtask

  task automatic test_tx_wrap();
    int sent = 0;
    int rcvd = 0;
    for (int cyc = 0; cyc < 2000 && rcvd < 40; cyc++) begin
      cpu_tx_wren   = (sent < 40) && cpu_tx_ready;
      cpu_tx_data   = 8'(8'h40 + sent);
      host_tx_ready = 1'($urandom_range(0, 1));
      if (host_tx_valid && host_tx_ready) begin
        checks++;
        if (host_tx_data !== 8'(8'h40 + rcvd)) begin
          errors++;
          $display("FAIL tx_wrap[%0d]: data=%h want %h", rcvd, host_tx_data, 8'(8'h40 + rcvd));
        end
        rcvd++;
      end
      if (cpu_tx_wren) sent++;
      tick();
    end
    cpu_tx_wren   = 1'b0;
    host_tx_ready = 1'b0;
    checks++;
    if (rcvd != 40 || tx_level !== 5'd0) begin
      errors++;
      $display("FAIL tx_wrap_done: received=%0d level=%0d want 40 0", rcvd, tx_level);
    end
  endtask

  task automatic test_underflow();
    cpu_rx_rden = 1'b1;
    tick();
    cpu_rx_rden = 1'b0;
    checks++;
    if (err_rx_underflow !== 1'b1 || rx_level !== 5'd0 || cpu_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_underflow: uf=%b level=%0d valid=%b want 1 0 0",
               err_rx_underflow, rx_level, cpu_rx_valid);
    end
    host_rx_valid = 1'b1;
    host_rx_data  = 8'h77;
    tick();
    host_rx_valid = 1'b0;
    cpu_rx_rden   = 1'b1;
    tick();
    cpu_rx_rden   = 1'b0;
    checks++;
    if (rx_level !== 5'd0 || cpu_rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_after_underflow: level=%0d valid=%b want 0 0", rx_level, cpu_rx_valid);
    end
  endtask

  task automatic test_async_reset();
    host_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_rx_valid = 1'b1;
      host_rx_data  = 8'(8'h80 + i);
      cpu_tx_wren   = 1'b1;
      cpu_tx_data   = 8'(8'h90 + i);
      tick();
    end
    host_rx_valid = 1'b0;
    cpu_tx_wren   = 1'b0;
    checks++;
    if (rx_level !== 5'd5 || tx_level !== 5'd5) begin
      errors++;
      $display("FAIL pre_reset_levels: rx=%0d tx=%0d want 5 5", rx_level, tx_level);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({rx_level, tx_level} !== 10'd0 || cpu_rx_valid !== 1'b0 || host_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_state: rx=%0d tx=%0d rxv=%b txv=%b want 0 0 0 0",
               rx_level, tx_level, cpu_rx_valid, host_tx_valid);
    end
    checks++;
    if (err_rx_underflow !== 1'b0 || err_tx_overflow !== 1'b0 ||
        host_rx_ready !== 1'b1 || cpu_tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_flags: uf=%b of=%b rxr=%b txr=%b want 0 0 1 1",
               err_rx_underflow, err_tx_overflow, host_rx_ready, cpu_tx_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

`ifdef SERIAL_BRIDGE_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 3; i++) begin
      host_rx_valid = 1'b1;
      host_rx_data  = 8'(i);
      tick();
    end
    host_rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_rx_rden = 1'b1;
      cpu_tx_wren = (i < 2);
      tick();
    end
    cpu_rx_rden = 1'b0;
    cpu_tx_wren = 1'b0;
    checks++;
    if (rx_bytes_total !== 16'd3 || tx_bytes_total !== 16'd2) begin
      errors++;
      $display("FAIL stats_count: rx=%0d tx=%0d want 3 2", rx_bytes_total, tx_bytes_total);
    end
    force dut.tx_total = 16'hFFFF;
    #1 release dut.tx_total;
    cpu_tx_wren = 1'b1;
    tick();
    cpu_tx_wren = 1'b0;
    checks++;
    if (tx_bytes_total !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_saturate: tx=%h want ffff", tx_bytes_total);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rx_basic();
    test_tx_fill_overflow();
    test_rx_full_simultaneous();
    test_tx_wrap();
    test_underflow();
    test_async_reset();
`ifdef SERIAL_BRIDGE_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
